// File: rtl/cpu_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cpu_sequencer: fetch/exec1/exec2/halt control sequencer for the 16-bit    |
// | CPU core, with interrupt take, retire strobe and memory-stall timeout.    |
// | Optional performance counters: define SEQ_PERF_COUNTERS_EN.               |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module cpu_sequencer #(
  parameter int MAX_WAIT = 15,
  parameter int COUNT_W  = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               sm_extra,
  input  logic               stp,
  input  logic               mem_ready,
  input  logic               irq,
  input  logic               irq_en,
  input  logic               resume,
  output logic [1:0]         state,
  output logic               retire,
  output logic               irq_take,
  output logic               halted,
  output logic               bus_timeout,
  output logic [COUNT_W-1:0] cycle_count,
  output logic [COUNT_W-1:0] retire_count
);

  localparam int                  c_WAIT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [c_WAIT_W-1:0] c_WAIT_MAX = c_WAIT_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_EXEC1 = 2'b10,
    ST_EXEC2 = 2'b01,
    ST_HALT  = 2'b11
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_WAIT_W-1:0] r_wait_cnt;
  logic                r_retire;
  logic                r_irq_take;
  logic                r_bus_timeout;
  logic                w_retire_nxt;
  logic                w_take_nxt;
  logic                w_timeout_nxt;
  logic                w_wait_inc;
  logic                w_irq;

  assign w_irq = irq & irq_en;

  always_comb begin
    w_state_nxt   = r_state;
    w_retire_nxt  = 1'b0;
    w_take_nxt    = 1'b0;
    w_timeout_nxt = r_bus_timeout;
    w_wait_inc    = 1'b0;
    case (r_state)
      ST_FETCH: begin
        if (mem_ready) begin
          w_state_nxt = ST_EXEC1;
        end else if (r_wait_cnt == c_WAIT_MAX) begin
          w_state_nxt   = ST_HALT;
          w_timeout_nxt = 1'b1;
        end else begin
          w_wait_inc = 1'b1;
        end
      end
      ST_EXEC1: begin
        if (stp) begin
          // A pending enabled interrupt overrides the halt request.
          w_retire_nxt = 1'b1;
          w_take_nxt   = w_irq;
          w_state_nxt  = w_irq ? ST_FETCH : ST_HALT;
        end else if (sm_extra) begin
          w_state_nxt = ST_EXEC2;
        end else begin
          w_retire_nxt = 1'b1;
          w_take_nxt   = w_irq;
          w_state_nxt  = ST_FETCH;
        end
      end
      ST_EXEC2: begin
        if (mem_ready) begin
          w_retire_nxt = 1'b1;
          w_take_nxt   = w_irq;
          w_state_nxt  = ST_FETCH;
        end else if (r_wait_cnt == c_WAIT_MAX) begin
          w_state_nxt   = ST_HALT;
          w_timeout_nxt = 1'b1;
        end else begin
          w_wait_inc = 1'b1;
        end
      end
      default: begin
        if (w_irq || resume) begin
          w_state_nxt   = ST_FETCH;
          w_take_nxt    = w_irq;
          w_timeout_nxt = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= ST_FETCH;
      r_wait_cnt    <= '0;
      r_retire      <= 1'b0;
      r_irq_take    <= 1'b0;
      r_bus_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_retire      <= w_retire_nxt;
      r_irq_take    <= w_take_nxt;
      r_bus_timeout <= w_timeout_nxt;
      if (w_state_nxt != r_state) begin
        r_wait_cnt <= '0;
      end else if (w_wait_inc) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
    end
  end

  assign state       = r_state;
  assign retire      = r_retire;
  assign irq_take    = r_irq_take;
  assign bus_timeout = r_bus_timeout;
  assign halted      = (r_state == ST_HALT);

`ifdef SEQ_PERF_COUNTERS_EN
  logic [COUNT_W-1:0] r_cycle_count;
  logic [COUNT_W-1:0] r_retire_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cycle_count  <= '0;
      r_retire_count <= '0;
    end else begin
      if (r_state != ST_HALT) begin
        r_cycle_count <= r_cycle_count + 1'b1;
      end
      if (w_retire_nxt) begin
        r_retire_count <= r_retire_count + 1'b1;
      end
    end
  end

  assign cycle_count  = r_cycle_count;
  assign retire_count = r_retire_count;
`else
  assign cycle_count  = '0;
  assign retire_count = '0;
`endif

endmodule
`default_nettype wire
